fifo_uart_tx: RTL and testbench

Read-side consumer of the 8-bit async FIFO, running entirely in the FIFO read-clock domain. It pops one byte whenever the FIFO is non-empty and the transmitter is free, then serializes it as a UART frame. The frame is start bit, DATA_WIDTH data bits LSB first, optional parity bit, and one stop bit. The FIFO read port is first-word-fall-through: read data is valid whenever empty is low, and the increment strobe advances the read pointer.

---
 rtl/fifo_uart_pkg.sv | 16 +
 rtl/baud_tick.sv | 27 ++
 rtl/fifo_uart_tx.sv | 141 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and line-level constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    // Counter reloads on clear or on its own terminal count, so it never wraps by overflow.
    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO read port, one frame per byte.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_inc,
    input  logic                  par_en,
    input  logic                  par_odd,
    output logic                  tx_out,
    output logic                  busy
);
    import fifo_uart_pkg::*;

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    tx_state_t             state, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_next;
    logic                  par_en_q, par_en_next;
    logic                  par_odd_q, par_odd_next;
    logic                  parity_q, parity_next;
    logic                  pop;
    logic                  tx_next;
    logic                  tick;
    logic                  baud_clear;

    // The timer is held at zero while idle and restarted whenever the state changes.
    assign baud_clear = (state == IDLE) || (state_next != state);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (tick)
    );

    // Next-state logic; the line level is derived from the state being entered so tx_out can be registered.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        par_en_next  = par_en_q;
        par_odd_next = par_odd_q;
        parity_next  = parity_q;
        pop          = 1'b0;
        tx_next      = IDLE_LEVEL;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_next = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                        shift_next   = shift_reg >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (pop) begin
            shift_next   = fifo_rd_data;
            bit_cnt_next = '0;
            par_en_next  = par_en;
            par_odd_next = par_odd;
            parity_next  = ^fifo_rd_data;
        end

        case (state_next)
            IDLE:    tx_next = IDLE_LEVEL;
            START:   tx_next = START_BIT;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_q ^ par_odd_q;
            STOP:    tx_next = STOP_BIT;
            default: tx_next = IDLE_LEVEL;
        endcase
    end

    // State, datapath and registered outputs; reset drops any frame in flight without re-reading it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            parity_q    <= 1'b0;
            tx_out      <= IDLE_LEVEL;
            busy        <= 1'b0;
            fifo_rd_inc <= 1'b0;
        end else begin
            state       <= state_next;
            shift_reg   <= shift_next;
            bit_cnt     <= bit_cnt_next;
            par_en_q    <= par_en_next;
            par_odd_q   <= par_odd_next;
            parity_q    <= parity_next;
            tx_out      <= tx_next;
            busy        <= (state_next != IDLE);
            fifo_rd_inc <= pop;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: a queue-backed FIFO feeds the transmitter and the line is compared against frames built from byte values.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic          clk;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_inc;
    logic          par_en;
    logic          par_odd;
    logic          tx_out;
    logic          busy;

    int checks;
    int errors;
    int pop_on_empty;

    logic [DW-1:0] fifo_q[$];

    logic tr_tx   [0:511];
    logic tr_busy [0:511];
    logic tr_inc  [0:511];
    logic exp_tx  [0:511];
    logic exp_busy[0:511];
    logic exp_inc [0:511];
    int   exp_len;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_inc (fifo_rd_inc),
        .par_en      (par_en),
        .par_odd     (par_odd),
        .tx_out      (tx_out),
        .busy        (busy)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fifo_sync();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] b);
        fifo_q.push_back(b);
        fifo_sync();
    endtask

    // Advance to the next falling edge; the FIFO model honours any pop strobe seen there.
    task automatic step();
        @(negedge clk);
        if (fifo_rd_inc === 1'b1) begin
            if (fifo_q.size() == 0) pop_on_empty++;
            else void'(fifo_q.pop_front());
            fifo_sync();
        end
    endtask

    task automatic capture(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            tr_tx[start + i]   = tx_out;
            tr_busy[start + i] = busy;
            tr_inc[start + i]  = fifo_rd_inc;
        end
    endtask

    task automatic wait_pop(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            if (fifo_rd_inc === 1'b1) ok = 1'b1;
        end
        tr_tx[0]   = tx_out;
        tr_busy[0] = busy;
        tr_inc[0]  = fifo_rd_inc;
    endtask

    // Reference frame: start, data LSB first, optional parity chosen to give the requested total parity, stop.
    task automatic add_frame(input logic [DW-1:0] b, input bit pe, input bit po);
        bit bits[$];
        int ones;
        int target;
        ones   = $countones(b);
        target = po ? 1 : 0;
        bits.push_back(1'b0);
        for (int k = 0; k < DW; k++) bits.push_back(b[k]);
        if (pe) bits.push_back((ones % 2) != target);
        bits.push_back(1'b1);
        for (int j = 0; j < bits.size(); j++) begin
            for (int c = 0; c < CPB; c++) begin
                exp_tx[exp_len]   = bits[j];
                exp_busy[exp_len] = 1'b1;
                exp_inc[exp_len]  = (j == 0 && c == 0);
                exp_len++;
            end
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_tx[exp_len]   = 1'b1;
            exp_busy[exp_len] = 1'b0;
            exp_inc[exp_len]  = 1'b0;
            exp_len++;
        end
    endtask

    task automatic trace_diff(input int sig, input int n, output int bad, output int first,
                              output logic got, output logic want);
        bad = 0; first = -1; got = 1'b0; want = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic a;
            logic e;
            case (sig)
                0:       begin a = tr_tx[i];   e = exp_tx[i];   end
                1:       begin a = tr_busy[i]; e = exp_busy[i]; end
                default: begin a = tr_inc[i];  e = exp_inc[i];  end
            endcase
            if (a !== e) begin
                if (first < 0) begin first = i; got = a; want = e; end
                bad++;
            end
        end
    endtask

    function automatic string sig_name(input int s);
        case (s)
            0:       return "tx";
            1:       return "busy";
            default: return "inc";
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (tx_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (fifo_rd_inc !== 1'b0) begin errors++; $display("[TB] FAIL reset_inc: got %b expected 0", fifo_rd_inc); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_single_byte();
        bit ok;
        int bad, first, nbusy, ninc;
        logic got, want;
        logic [9:0] spec_bits;
        spec_bits = 10'b1101001010;
        par_en = 1'b0; par_odd = 1'b0; exp_len = 0;
        push(8'hA5);
        wait_pop(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL single_pop: no pop within 50 cycles, expected 1"); return; end
        capture(1, 43);
        add_frame(8'hA5, 1'b0, 1'b0);
        add_idle(4);
        for (int s = 0; s < 3; s++) begin
            trace_diff(s, exp_len, bad, first, got, want);
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL single_%s: %0d bad cycles, first at %0d got %b expected %b", sig_name(s), bad, first, got, want);
            end
        end
        bad = 0;
        for (int k = 0; k < 10; k++)
            for (int c = 0; c < CPB; c++)
                if (tr_tx[k*CPB + c] !== spec_bits[k]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL single_literal_bits: %0d bad cycles expected 0", bad); end
        nbusy = 0; ninc = 0;
        for (int i = 0; i < 44; i++) begin
            if (tr_busy[i] === 1'b1) nbusy++;
            if (tr_inc[i] === 1'b1) ninc++;
        end
        checks++;
        if (nbusy != 40) begin errors++; $display("[TB] FAIL single_busy_len: got %0d expected 40", nbusy); end
        checks++;
        if (ninc != 1) begin errors++; $display("[TB] FAIL single_pulse_count: got %0d expected 1", ninc); end
    endtask

    task automatic test_parity();
        bit ok;
        int bad, first, nbusy;
        logic got, want;
        for (int po = 0; po < 2; po++) begin
            par_en = 1'b1; par_odd = po[0]; exp_len = 0;
            push(8'h07);
            wait_pop(ok);
            checks++;
            if (!ok) begin errors++; $display("[TB] FAIL parity_pop: no pop within 50 cycles, expected 1"); return; end
            capture(1, 47);
            add_frame(8'h07, 1'b1, po[0]);
            add_idle(4);
            for (int s = 0; s < 3; s++) begin
                trace_diff(s, exp_len, bad, first, got, want);
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("[TB] FAIL parity%0d_%s: %0d bad cycles, first at %0d got %b expected %b", po, sig_name(s), bad, first, got, want);
                end
            end
            checks++;
            if (tr_tx[9*CPB + 1] !== (po == 0)) begin
                errors++;
                $display("[TB] FAIL parity%0d_bit: got %b expected %b", po, tr_tx[9*CPB + 1], (po == 0));
            end
            nbusy = 0;
            for (int i = 0; i < 48; i++) if (tr_busy[i] === 1'b1) nbusy++;
            checks++;
            if (nbusy != 44) begin errors++; $display("[TB] FAIL parity%0d_frame_len: got %0d expected 44", po, nbusy); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad, first, nbusy;
        logic got, want;
        par_en = 1'b0; par_odd = 1'b0; exp_len = 0;
        push(8'h55);
        push(8'h0F);
        wait_pop(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL b2b_pop: no pop within 50 cycles, expected 1"); return; end
        capture(1, 83);
        add_frame(8'h55, 1'b0, 1'b0);
        add_frame(8'h0F, 1'b0, 1'b0);
        add_idle(4);
        for (int s = 0; s < 3; s++) begin
            trace_diff(s, exp_len, bad, first, got, want);
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL b2b_%s: %0d bad cycles, first at %0d got %b expected %b", sig_name(s), bad, first, got, want);
            end
        end
        nbusy = 0;
        for (int i = 0; i < 80; i++) if (tr_busy[i] === 1'b1) nbusy++;
        checks++;
        if (nbusy != 80) begin errors++; $display("[TB] FAIL b2b_busy_continuous: got %0d expected 80", nbusy); end
        checks++;
        if (tr_inc[40] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_pulse: got %b expected 1", tr_inc[40]); end
    endtask

    task automatic test_empty();
        int bad_tx, bad_busy, bad_inc;
        bad_tx = 0; bad_busy = 0; bad_inc = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tx_out !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            if (fifo_rd_inc !== 1'b0) bad_inc++;
        end
        checks++;
        if (bad_tx != 0) begin errors++; $display("[TB] FAIL empty_tx: %0d cycles not idle, expected 0", bad_tx); end
        checks++;
        if (bad_busy != 0) begin errors++; $display("[TB] FAIL empty_busy: %0d cycles busy, expected 0", bad_busy); end
        checks++;
        if (bad_inc != 0) begin errors++; $display("[TB] FAIL empty_inc: %0d pops, expected 0", bad_inc); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        bit pe, po;
        int bad, first;
        logic got, want;
        logic [DW-1:0] b0, b1;
        pe = 1'($urandom); po = 1'($urandom);
        b0 = 8'($urandom); b1 = 8'($urandom);
        par_en = pe; par_odd = po; exp_len = 0;
        push(b0);
        wait_pop(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL rstmid_pop: no pop within 50 cycles, expected 1"); return; end
        capture(1, 17);
        rst = 1'b1;
        push(b1);
        step();
        checks++;
        if (tx_out !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_tx: got %b expected 1", tx_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        checks++;
        if (fifo_rd_inc !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_inc: got %b expected 0", fifo_rd_inc); end
        rst = 1'b0;
        step();
        tr_tx[0] = tx_out; tr_busy[0] = busy; tr_inc[0] = fifo_rd_inc;
        checks++;
        if (fifo_rd_inc !== 1'b1 || tx_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_fresh_start: got inc=%b tx=%b expected inc=1 tx=0", fifo_rd_inc, tx_out);
        end
        add_frame(b1, pe, po);
        add_idle(4);
        capture(1, exp_len - 1);
        for (int s = 0; s < 3; s++) begin
            trace_diff(s, exp_len, bad, first, got, want);
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL rstmid_%s: %0d bad cycles, first at %0d got %b expected %b", sig_name(s), bad, first, got, want);
            end
        end
    endtask

    task automatic test_config_change();
        bit ok;
        bit po;
        int bad, first, nbusy;
        logic got, want;
        logic [DW-1:0] b0, b1;
        b0 = 8'($urandom); b1 = 8'($urandom); po = 1'($urandom);
        par_en = 1'b0; par_odd = 1'b0; exp_len = 0;
        push(b0);
        push(b1);
        wait_pop(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL cfg_pop: no pop within 50 cycles, expected 1"); return; end
        capture(1, 9);
        par_en = 1'b1; par_odd = po;
        capture(10, 78);
        add_frame(b0, 1'b0, 1'b0);
        add_frame(b1, 1'b1, po);
        add_idle(4);
        for (int s = 0; s < 3; s++) begin
            trace_diff(s, exp_len, bad, first, got, want);
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL cfg_%s: %0d bad cycles, first at %0d got %b expected %b", sig_name(s), bad, first, got, want);
            end
        end
        nbusy = 0;
        for (int i = 0; i < 88; i++) if (tr_busy[i] === 1'b1) nbusy++;
        checks++;
        if (nbusy != 84) begin errors++; $display("[TB] FAIL cfg_total_len: got %0d expected 84", nbusy); end
        par_en = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        bit pe, po;
        int n, bad, first;
        logic got, want;
        logic [DW-1:0] b;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 3);
            pe = 1'($urandom); po = 1'($urandom);
            par_en = pe; par_odd = po; exp_len = 0;
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                push(b);
                add_frame(b, pe, po);
            end
            add_idle(4);
            wait_pop(ok);
            checks++;
            if (!ok) begin errors++; $display("[TB] FAIL rand%0d_pop: no pop within 50 cycles, expected 1", it); return; end
            capture(1, exp_len - 1);
            for (int s = 0; s < 3; s++) begin
                trace_diff(s, exp_len, bad, first, got, want);
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_%s: %0d bad cycles, first at %0d got %b expected %b", it, sig_name(s), bad, first, got, want);
                end
            end
        end
        checks++;
        if (fifo_q.size() != 0) begin errors++; $display("[TB] FAIL fifo_drained: got %0d entries expected 0", fifo_q.size()); end
        checks++;
        if (pop_on_empty != 0) begin errors++; $display("[TB] FAIL pop_on_empty: got %0d expected 0", pop_on_empty); end
    endtask

    // Scenario sequence followed by the one-line summary.
    initial begin
        checks = 0; errors = 0; pop_on_empty = 0; exp_len = 0;
        rst = 1'b1; par_en = 1'b0; par_odd = 1'b0;
        fifo_sync();
        test_reset();
        test_single_byte();
        test_parity();
        test_back_to_back();
        test_empty();
        test_reset_mid_frame();
        test_config_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
